// File: rtl/rsa_link_ctrl.sv
// Purpose : byte-serial command front end for a modular-exponentiation engine.
// Latency : ACK/NAK one cycle after the last frame byte; eng_start one cycle after the last RUN byte.
// Backpr. : transmit waits for tx_busy=0 and never issues tx_valid on back-to-back cycles.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   rx_valid/rx_byte     received byte stream (one-cycle pulses)
//   tx_busy              UART transmitter busy
//   tx_valid/tx_byte     transmit request pulse and byte (tx_byte held until next request)
//   eng_start            one-cycle engine start pulse
//   eng_n/eng_e/eng_m    engine operands (held from eng_start through eng_done)
//   eng_done/eng_ans     engine completion pulse and result
//   busy                 high in any state other than IDLE
//   err                  one-cycle pulse per protocol error
//
// Frame: command byte (opcode [7:4], slot [SLOT_BITS-1:0]) then BITLEN/8 payload bytes, LSB first.
// Optional build macro RSA_LINK_CKSUM_EN adds an XOR checksum byte after each payload and result.

module rsa_link_ctrl #(
    parameter int BITLEN    = 64,
    parameter int SLOT_BITS = 1,
    parameter int TIMEOUT   = 1200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_busy,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    output logic              eng_start,
    output logic [BITLEN-1:0] eng_n,
    output logic [BITLEN-1:0] eng_e,
    output logic [BITLEN-1:0] eng_m,
    input  logic              eng_done,
    input  logic [BITLEN-1:0] eng_ans,
    output logic              busy,
    output logic              err
);

    localparam int NBYTES = BITLEN / 8;
`ifdef RSA_LINK_CKSUM_EN
    localparam int LEN = NBYTES + 1;
`else
    localparam int LEN = NBYTES;
`endif
    localparam int CW    = $clog2(LEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int NSLOT = 2 ** SLOT_BITS;

    localparam logic [3:0] OP_LOAD_N = 4'h1;
    localparam logic [3:0] OP_LOAD_E = 4'h2;
    localparam logic [3:0] OP_RUN    = 4'h3;
    localparam logic [7:0] ACK       = 8'hA5;
    localparam logic [7:0] NAK       = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_EXEC,
        S_SEND,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [3:0]         r_op;
    logic [SLOT_BITS-1:0] r_slot;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_tmo;
    logic [BITLEN-1:0]  r_shadow;
    logic [BITLEN-1:0]  r_result;
    logic [BITLEN-1:0]  r_slot_n [NSLOT];
    logic [BITLEN-1:0]  r_slot_e [NSLOT];
    logic [7:0]         r_resp;
    logic               r_tx_valid;
    logic [7:0]         r_tx_byte;
    logic               r_eng_start;
    logic               r_start_pend;
    logic [BITLEN-1:0]  r_eng_n;
    logic [BITLEN-1:0]  r_eng_e;
    logic [BITLEN-1:0]  r_eng_m;
    logic               r_err;
`ifdef RSA_LINK_CKSUM_EN
    logic [7:0]         r_rxsum;
    logic [7:0]         r_txsum;
`endif

    logic              w_op_ok;
    logic              w_last_rx;
    logic              w_tx_ok;
    logic              w_cksum_ok;
    logic [BITLEN-1:0] w_shadow_next;
    logic [BITLEN-1:0] w_frame;

    assign w_op_ok       = (rx_byte[7:4] == OP_LOAD_N) || (rx_byte[7:4] == OP_LOAD_E) ||
                           (rx_byte[7:4] == OP_RUN);
    assign w_last_rx     = (r_cnt == CW'(LEN - 1));
    // Never request on consecutive cycles so the UART has time to raise tx_busy.
    assign w_tx_ok       = !tx_busy && !r_tx_valid;
    assign w_shadow_next = {rx_byte, r_shadow[BITLEN-1:8]};

`ifdef RSA_LINK_CKSUM_EN
    // Last byte is the checksum; the shadow already holds the full payload.
    assign w_frame    = r_shadow;
    assign w_cksum_ok = (rx_byte == r_rxsum);
`else
    // Last byte is payload; commit the value including it.
    assign w_frame    = w_shadow_next;
    assign w_cksum_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_slot       <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_shadow     <= '0;
            r_result     <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                r_slot_n[i] <= '0;
                r_slot_e[i] <= '0;
            end
            r_resp       <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_eng_start  <= 1'b0;
            r_start_pend <= 1'b0;
            r_eng_n      <= '0;
            r_eng_e      <= '0;
            r_eng_m      <= '0;
            r_err        <= 1'b0;
`ifdef RSA_LINK_CKSUM_EN
            r_rxsum      <= '0;
            r_txsum      <= '0;
`endif
        end else begin
            r_tx_valid  <= 1'b0;
            r_eng_start <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (w_op_ok) begin
                            r_op    <= rx_byte[7:4];
                            r_slot  <= rx_byte[SLOT_BITS-1:0];
                            r_cnt   <= '0;
                            r_tmo   <= '0;
`ifdef RSA_LINK_CKSUM_EN
                            r_rxsum <= '0;
`endif
                            r_state <= S_PAYLOAD;
                        end else begin
                            r_resp  <= NAK;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (rx_valid) begin
                        r_tmo <= '0;
                        r_cnt <= r_cnt + 1'b1;
`ifdef RSA_LINK_CKSUM_EN
                        if (!w_last_rx) begin
                            r_shadow <= w_shadow_next;
                            r_rxsum  <= r_rxsum ^ rx_byte;
                        end
`else
                        r_shadow <= w_shadow_next;
`endif
                        if (w_last_rx) begin
                            r_cnt <= '0;
                            if (!w_cksum_ok) begin
                                r_resp  <= NAK;
                                r_err   <= 1'b1;
                                r_state <= S_RESP;
                            end else if (r_op == OP_RUN) begin
                                // Operands settle this cycle; start follows one cycle later.
                                r_eng_n      <= r_slot_n[r_slot];
                                r_eng_e      <= r_slot_e[r_slot];
                                r_eng_m      <= w_frame;
                                r_start_pend <= 1'b1;
                                r_state      <= S_EXEC;
                            end else begin
                                if (r_op == OP_LOAD_N) begin
                                    r_slot_n[r_slot] <= w_frame;
                                end else begin
                                    r_slot_e[r_slot] <= w_frame;
                                end
                                r_resp  <= ACK;
                                r_state <= S_RESP;
                            end
                        end
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        // Silent abort: nothing committed, nothing transmitted.
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_EXEC: begin
                    if (rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (r_start_pend) begin
                        r_eng_start  <= 1'b1;
                        r_start_pend <= 1'b0;
                    end else if (eng_done) begin
                        r_result <= eng_ans;
                        r_cnt    <= '0;
`ifdef RSA_LINK_CKSUM_EN
                        r_txsum  <= '0;
`endif
                        r_state  <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (w_tx_ok) begin
                        r_tx_valid <= 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
`ifdef RSA_LINK_CKSUM_EN
                        if (r_cnt == CW'(NBYTES)) begin
                            r_tx_byte <= r_txsum;
                        end else begin
                            r_tx_byte <= r_result[7:0];
                            r_txsum   <= r_txsum ^ r_result[7:0];
                            r_result  <= r_result >> 8;
                        end
`else
                        r_tx_byte <= r_result[7:0];
                        r_result  <= r_result >> 8;
`endif
                        if (r_cnt == CW'(LEN - 1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_RESP: begin
                    if (rx_valid) begin
                        r_err <= 1'b1;
                    end
                    if (w_tx_ok) begin
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= r_resp;
                        r_state    <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_byte   = r_tx_byte;
    assign eng_start = r_eng_start;
    assign eng_n     = r_eng_n;
    assign eng_e     = r_eng_e;
    assign eng_m     = r_eng_m;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_rsa_link_ctrl.sv
// Purpose : scoreboard bench for rsa_link_ctrl (BITLEN=16, SLOT_BITS=1, short TIMEOUT).
// Latency : expected tx bytes / engine operands are queued by stimulus, checked by monitors.
// Backpr. : a UART model holds tx_busy for three cycles after each tx_valid.

module tb_rsa_link_ctrl;

    localparam int BITLEN    = 16;
    localparam int SLOT_BITS = 1;
    localparam int TIMEOUT   = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              tx_busy = 1'b0;
    logic              tx_valid;
    logic [7:0]        tx_byte;
    logic              eng_start;
    logic [BITLEN-1:0] eng_n;
    logic [BITLEN-1:0] eng_e;
    logic [BITLEN-1:0] eng_m;
    logic              eng_done = 1'b0;
    logic [BITLEN-1:0] eng_ans = '0;
    logic              busy;
    logic              err;

    rsa_link_ctrl #(
        .BITLEN    (BITLEN),
        .SLOT_BITS (SLOT_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_busy   (tx_busy),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .eng_start (eng_start),
        .eng_n     (eng_n),
        .eng_e     (eng_e),
        .eng_m     (eng_m),
        .eng_done  (eng_done),
        .eng_ans   (eng_ans),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          failures = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    int          busy_cnt = 0;
    int          eng_cd = 0;
    logic        prev_txv = 1'b0;
    logic [47:0] eng_held = '0;
    logic [15:0] ans_model = '0;
    logic [7:0]  exp_tx[$];
    logic [47:0] exp_eng[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [15:0] p);
        send_byte(cmd);
        send_byte(p[7:0]);
        send_byte(p[15:8]);
`ifdef RSA_LINK_CKSUM_EN
        send_byte(p[7:0] ^ p[15:8]);
`endif
    endtask

    task automatic push_result(input logic [15:0] a);
        exp_tx.push_back(a[7:0]);
        exp_tx.push_back(a[15:8]);
`ifdef RSA_LINK_CKSUM_EN
        exp_tx.push_back(a[7:0] ^ a[15:8]);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_tx.size() != 0) && n < 400);
        check({name, "_busy"}, busy, 0);
        check({name, "_txq"}, exp_tx.size(), 0);
        check({name, "_err"}, err_cnt, exp_err);
    endtask

    task automatic wait_tx(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!tx_valid && n < 200);
        check(name, tx_valid, 1);
    endtask

    // Monitor: scoreboard for transmitted bytes, handshake rules, err pulses; UART busy model.
    initial begin
        forever begin
            @(negedge clk);
            if (err) err_cnt++;
            if (tx_valid) begin
                check("tx_gap", prev_txv, 0);
                check("tx_busy_ok", tx_busy, 0);
                if (exp_tx.size() == 0) check("tx_unexpected", tx_valid, 0);
                else check("tx_byte", tx_byte, exp_tx.pop_front());
                busy_cnt = 3;
            end
            prev_txv = tx_valid;
            tx_busy  = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    // Engine model: checks operands at start, answers after four cycles, checks operand hold.
    initial begin
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (rst) eng_cd = 0;
            if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    check("eng_hold", {eng_n, eng_e, eng_m}, eng_held);
                    eng_ans  = ans_model;
                    eng_done = 1'b1;
                end
            end
            if (eng_start) begin
                if (exp_eng.size() == 0) check("eng_start_unexpected", eng_start, 0);
                else check("eng_operands", {eng_n, eng_e, eng_m}, exp_eng.pop_front());
                eng_held = {eng_n, eng_e, eng_m};
                eng_cd   = 4;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        tests++;
        failures++;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_eng_start", eng_start, 0);
        @(negedge clk);
        rst = 1'b0;

        // Load slot 0 N and E.
        exp_tx.push_back(8'hA5);
        frame(8'h10, 16'h00BB);
        wait_idle("load_n");
        exp_tx.push_back(8'hA5);
        frame(8'h20, 16'h0007);
        wait_idle("load_e");

        // RUN on slot 0, with a stray byte during SEND.
        ans_model = 16'h0080;
        exp_eng.push_back({16'h00BB, 16'h0007, 16'h0002});
        push_result(16'h0080);
        frame(8'h30, 16'h0002);
        wait_tx("run_first_tx");
        send_byte(8'hFF);
        exp_err++;
        wait_idle("run0");

        // Invalid opcode.
        exp_tx.push_back(8'h5A);
        exp_err++;
        send_byte(8'h70);
        wait_idle("nak");

`ifdef RSA_LINK_CKSUM_EN
        // Bad checksum on LOAD_N: NAK, slot unchanged.
        exp_tx.push_back(8'h5A);
        exp_err++;
        send_byte(8'h10);
        send_byte(8'hBB);
        send_byte(8'h00);
        send_byte(8'hBA);
        wait_idle("bad_cksum");
`endif

        // Slot 0 must be unchanged after NAKs.
        ans_model = 16'hBEEF;
        exp_eng.push_back({16'h00BB, 16'h0007, 16'h0003});
        push_result(16'hBEEF);
        frame(8'h30, 16'h0003);
        wait_idle("run0_again");

        // Partial frame then silence: abort after TIMEOUT idle cycles, no tx.
        send_byte(8'h11);
        send_byte(8'h55);
        repeat (TIMEOUT - 5) @(negedge clk);
        #1;
        check("tmo_not_early_busy", busy, 1);
        check("tmo_not_early_err", err_cnt, exp_err);
        exp_err++;
        repeat (10) @(negedge clk);
        #1;
        check("tmo_busy", busy, 0);
        check("tmo_err", err_cnt, exp_err);

        // Slot 1 N must still be zero.
        ans_model = 16'h1234;
        exp_eng.push_back({16'h0000, 16'h0000, 16'h0005});
        push_result(16'h1234);
        frame(8'h31, 16'h0005);
        wait_idle("run1");

        // Reset in the middle of SEND.
        ans_model = 16'h5678;
        exp_eng.push_back({16'h00BB, 16'h0007, 16'h0009});
        push_result(16'h5678);
        frame(8'h30, 16'h0009);
        wait_tx("mid_send_tx");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("msr_tx_valid", tx_valid, 0);
        check("msr_tx_byte", tx_byte, 8'h00);
        check("msr_busy", busy, 0);
        check("msr_err", err, 0);
        check("msr_eng_start", eng_start, 0);
        exp_tx.delete();
        @(negedge clk);
        rst = 1'b0;

        // Reset cleared slot 0.
        ans_model = 16'h0000;
        exp_eng.push_back({16'h0000, 16'h0000, 16'h0001});
        push_result(16'h0000);
        frame(8'h30, 16'h0001);
        wait_idle("run_after_rst");

        repeat (10) @(negedge clk);
        check("eng_queue_empty", exp_eng.size(), 0);
        check("final_err", err_cnt, exp_err);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/rsa_link_ctrl.md
RSA_LINK_CTRL -- requirements
Module: rsa_link_ctrl

Interface
REQ-001 SHALL have parameter BITLEN, default 64: operand width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter SLOT_BITS, default 1: key-slot index width; 2**SLOT_BITS (N,E) slots.
REQ-003 SHALL have parameter TIMEOUT, default 1200000: maximum idle clk cycles between bytes inside a frame.
REQ-004 SHALL have ports (name dir width meaning):
  clk  in  1  single clock, all logic on rising edge;
  rst  in  1  synchronous, active-high reset;
  rx_valid  in  1  one-cycle pulse, rx_byte valid;
  rx_byte  in  8  received byte;
  tx_busy  in  1  UART transmitter busy;
  tx_valid  out  1  one-cycle transmit request;
  tx_byte  out  8  byte to transmit;
  eng_start  out  1  one-cycle engine start pulse;
  eng_n, eng_e, eng_m  out  BITLEN  modulus, exponent, message to engine;
  eng_done  in  1  one-cycle engine completion pulse;
  eng_ans  in  BITLEN  engine result, valid with eng_done;
  busy  out  1  high in any state other than IDLE;
  err  out  1  one-cycle pulse per protocol error.

Function
REQ-005 SHALL decode command byte as opcode=[7:4], slot=[SLOT_BITS-1:0]; opcodes 0x1 LOAD_N, 0x2 LOAD_E, 0x3 RUN; all others are invalid.
REQ-006 SHALL implement states IDLE, PAYLOAD, EXEC, SEND, RESP.
REQ-007 IDLE: valid command goes to PAYLOAD with byte counter cleared; invalid opcode goes to RESP with NAK 0x5A and pulses err.
REQ-008 PAYLOAD SHALL accept BITLEN/8 bytes, least-significant first, into a shadow shift register; slot registers stay unchanged until the frame commits.
REQ-009 Frame end, LOAD_N/LOAD_E: commit shadow to the slot's N/E register, then go to RESP with ACK 0xA5.
REQ-010 Frame end, RUN: drive eng_n/eng_e from the slot and eng_m from shadow, pulse eng_start exactly one cycle later, then enter EXEC.
REQ-011 eng_n/eng_e/eng_m SHALL hold stable from the eng_start cycle through the eng_done cycle.
REQ-012 EXEC: on eng_done, capture eng_ans into the result shift register and enter SEND.
REQ-013 SEND: transmit BITLEN/8 result bytes, least-significant first, then return to IDLE.
REQ-014 RESP: transmit one ACK/NAK byte, then return to IDLE.
REQ-015 Transmit handshake: assert tx_valid for one cycle only when tx_busy=0 and tx_valid was 0 on the previous cycle; tx_byte stays stable until the next tx_valid.
REQ-016 rx_valid in EXEC, SEND or RESP SHALL discard the byte and pulse err; state and data are unaffected.
REQ-017 PAYLOAD inter-byte counter reaching TIMEOUT SHALL abort the frame, leave registers unchanged, pulse err and return to IDLE without transmitting.
REQ-018 eng_done outside EXEC SHALL be ignored.
REQ-019 rx_valid and eng_done in the same EXEC cycle: capture the result and pulse err for the discarded byte.

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE and clear counters, all slot, shadow and result registers, and tx_byte to 0x00.
REQ-021 rst SHALL clear tx_valid, eng_start, busy and err to 0, including mid-frame, mid-EXEC and mid-SEND; a later eng_done is ignored per REQ-018.

Configuration
REQ-022 Macro RSA_LINK_CKSUM_EN: when defined, every payload is followed by one byte equal to the XOR of the payload bytes.
REQ-023 With the macro, a checksum mismatch SHALL NAK, pulse err and commit nothing (no engine start on RUN).
REQ-024 With the macro, SEND SHALL append the XOR of the result bytes after the last result byte.
REQ-025 Without RSA_LINK_CKSUM_EN, no checksum byte is expected or sent and frame lengths are exactly 1+BITLEN/8 bytes.

Verification (BITLEN=16, SLOT_BITS=1, macro undefined unless stated)
REQ-026 0x10,0xBB,0x00 then 0x20,0x07,0x00 -> two ACK 0xA5 bytes; slot0 N=0x00BB, E=0x0007.
REQ-027 Then 0x30,0x02,0x00 with the engine model returning 0x0080 -> eng_start pulses once with eng_m=0x0002; tx bytes are 0x80 then 0x00; busy falls afterwards.
REQ-028 Command 0x70 -> NAK 0x5A, one err pulse, no slot changes.
REQ-029 0x11,0x55 then silence for TIMEOUT cycles -> err pulse, return to IDLE, slot1 N still 0x0000, no tx.
REQ-030 rx byte during SEND -> err pulse, result bytes unchanged; rst asserted mid-SEND -> tx_valid low next cycle and all outputs at reset values.
REQ-031 With macro defined: 0x10,0xBB,0x00,0xBA -> NAK and N unchanged; checksum 0xBB -> ACK and N=0x00BB.
